// File: rtl/quote_order_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : quote_order_pkg
// Brief    : Shared types and constants for the quote order generator.
// Revision : 1.0 - initial release
// ============================================================================
package quote_order_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EVAL    = 3'd1,
        SEND_W0 = 3'd2,
        SEND_W1 = 3'd3,
        SEND_W2 = 3'd4,
        SEND_W3 = 3'd5
    } state_t;

    localparam logic [1:0] WORD_HDR = 2'd0;
    localparam logic [1:0] WORD_BID = 2'd1;
    localparam logic [1:0] WORD_ASK = 2'd2;
    localparam logic [1:0] WORD_QTY = 2'd3;

    localparam logic [31:0] BID_EMPTY     = 32'h0000_0000;
    localparam logic [31:0] ASK_EMPTY     = 32'hFFFF_FFFF;
    localparam logic [15:0] DEFAULT_MAGIC = 16'hA55A;

    // An empty side of the book is reported with the sentinel price.
    function automatic logic book_valid(input logic [31:0] bid, input logic [31:0] ask);
        return (bid != BID_EMPTY) && (ask != ASK_EMPTY) && (ask > bid);
    endfunction

endpackage
`default_nettype wire

// File: rtl/quote_order_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : quote_order_gen_if
// Brief    : AXI-Stream order egress bus (32-bit data, last marker).
// Revision : 1.0 - initial release
// ============================================================================
interface quote_order_gen_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/quote_order_gen_token_bucket.sv
`default_nettype none
// ============================================================================
// Module   : token_bucket
// Brief    : Saturating token bucket refilled once every REFILL_CYCLES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module token_bucket #(
    parameter int TOKEN_MAX     = 4,
    parameter int REFILL_CYCLES = 1000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic consume,
    output logic      has_token
);

    localparam int              c_cnt_w    = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFILL_CYCLES - 1);
    localparam logic [3:0]      c_tok_max  = 4'(TOKEN_MAX);

    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_tokens;
    logic               w_refill;

    assign w_refill  = (r_cnt == c_cnt_last);
    assign has_token = (r_tokens != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_tokens <= c_tok_max;
        end else begin
            r_cnt <= w_refill ? '0 : r_cnt + 1'b1;
            // A refill landing on a consume cancels out.
            if (consume && !w_refill && (r_tokens != 4'd0)) begin
                r_tokens <= r_tokens - 4'd1;
            end else if (w_refill && !consume && (r_tokens != c_tok_max)) begin
                r_tokens <= r_tokens + 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/quote_order_gen.sv
`default_nettype none
// ============================================================================
// Module   : quote_order_gen
// Brief    : Turns BBO updates into rate-limited, de-duplicated 4-word quotes.
// Revision : 1.0 - initial release
// ============================================================================
import quote_order_pkg::*;

module quote_order_gen #(
    parameter int          TOKEN_MAX     = 4,
    parameter int          REFILL_CYCLES = 1000,
    parameter logic [15:0] MAGIC         = DEFAULT_MAGIC
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] best_bid,
    input  wire logic [31:0] best_ask,
    input  wire logic        bbo_updated,
    input  wire logic        cfg_enable,
    input  wire logic [31:0] cfg_max_spread,
    input  wire logic [31:0] cfg_order_qty,
    quote_order_gen_if.master m_axis,
    output logic [15:0]      orders_sent,
    output logic [15:0]      rate_drops
);

    state_t      r_state;
    logic [31:0] r_snap_bid, r_snap_ask;
    logic [31:0] r_pend_bid, r_pend_ask;
    logic [31:0] r_last_bid, r_last_ask;
    logic [31:0] r_qty, r_tdata;
    logic        r_pending, r_tvalid, r_tlast;
    logic [15:0] r_seq, r_orders_sent, r_rate_drops;

    logic [31:0] w_spread;
    logic        w_trigger, w_has_token, w_consume, w_handshake;

    assign w_spread    = r_snap_ask - r_snap_bid;
    assign w_trigger   = cfg_enable && book_valid(r_snap_bid, r_snap_ask)
                       && (w_spread <= cfg_max_spread)
                       && !((r_snap_bid == r_last_bid) && (r_snap_ask == r_last_ask));
    assign w_consume   = (r_state == EVAL) && w_trigger && w_has_token;
    assign w_handshake = r_tvalid && m_axis.tready;

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign orders_sent   = r_orders_sent;
    assign rate_drops    = r_rate_drops;

    token_bucket #(
        .TOKEN_MAX     (TOKEN_MAX),
        .REFILL_CYCLES (REFILL_CYCLES)
    ) u_token_bucket (
        .clk       (clk),
        .rst       (rst),
        .consume   (w_consume),
        .has_token (w_has_token)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_snap_bid    <= '0;
            r_snap_ask    <= '0;
            r_pend_bid    <= '0;
            r_pend_ask    <= '0;
            r_last_bid    <= '0;
            r_last_ask    <= '0;
            r_qty         <= '0;
            r_tdata       <= '0;
            r_pending     <= 1'b0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_seq         <= '0;
            r_orders_sent <= '0;
            r_rate_drops  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bbo_updated) begin
                        r_snap_bid <= best_bid;
                        r_snap_ask <= best_ask;
                        r_state    <= EVAL;
                    end
                end
                EVAL: begin
                    if (w_consume) begin
                        r_last_bid <= r_snap_bid;
                        r_last_ask <= r_snap_ask;
                        r_qty      <= cfg_order_qty;
                        r_tdata    <= {MAGIC, r_seq};
                        r_tvalid   <= 1'b1;
                        r_tlast    <= 1'b0;
                        r_state    <= SEND_W0;
                        if (bbo_updated) begin
                            r_pend_bid <= best_bid;
                            r_pend_ask <= best_ask;
                            r_pending  <= 1'b1;
                        end
                    end else begin
                        if (w_trigger) begin
                            r_rate_drops <= r_rate_drops + 16'd1;
                        end
                        // A sample arriving while this one is rejected is evaluated next.
                        if (bbo_updated) begin
                            r_snap_bid <= best_bid;
                            r_snap_ask <= best_ask;
                            r_state    <= EVAL;
                        end else begin
                            r_state    <= IDLE;
                        end
                    end
                end
                SEND_W0, SEND_W1, SEND_W2: begin
                    if (bbo_updated) begin
                        r_pend_bid <= best_bid;
                        r_pend_ask <= best_ask;
                        r_pending  <= 1'b1;
                    end
                    if (w_handshake) begin
                        case (r_state)
                            SEND_W0: begin
                                r_tdata <= r_last_bid;
                                r_state <= SEND_W1;
                            end
                            SEND_W1: begin
                                r_tdata <= r_last_ask;
                                r_state <= SEND_W2;
                            end
                            default: begin
                                r_tdata <= r_qty;
                                r_tlast <= 1'b1;
                                r_state <= SEND_W3;
                            end
                        endcase
                    end
                end
                SEND_W3: begin
                    if (w_handshake) begin
                        r_tvalid      <= 1'b0;
                        r_tlast       <= 1'b0;
                        r_seq         <= r_seq + 16'd1;
                        r_orders_sent <= r_orders_sent + 16'd1;
                        r_pending     <= 1'b0;
                        // A coincident update supersedes whatever was pending.
                        if (bbo_updated) begin
                            r_snap_bid <= best_bid;
                            r_snap_ask <= best_ask;
                            r_state    <= EVAL;
                        end else if (r_pending) begin
                            r_snap_bid <= r_pend_bid;
                            r_snap_ask <= r_pend_ask;
                            r_state    <= EVAL;
                        end else begin
                            r_state    <= IDLE;
                        end
                    end else if (bbo_updated) begin
                        r_pend_bid <= best_bid;
                        r_pend_ask <= best_ask;
                        r_pending  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quote_order_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_quote_order_gen
// Brief    : Scoreboard bench for quote_order_gen (expected words queued at stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_quote_order_gen;

    localparam int          TOKEN_MAX     = 2;
    localparam int          REFILL_CYCLES = 10000;
    localparam logic [15:0] MAGIC         = 16'hA55A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] best_bid = '0;
    logic [31:0] best_ask = '0;
    logic        bbo_updated = 1'b0;
    logic        cfg_enable = 1'b1;
    logic [31:0] cfg_max_spread = 32'd10;
    logic [31:0] cfg_order_qty = 32'd50;
    logic        tready = 1'b1;
    logic [15:0] orders_sent, rate_drops;

    quote_order_gen_if m_axis();
    assign m_axis.tready = tready;

    quote_order_gen #(
        .TOKEN_MAX     (TOKEN_MAX),
        .REFILL_CYCLES (REFILL_CYCLES),
        .MAGIC         (MAGIC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .best_bid       (best_bid),
        .best_ask       (best_ask),
        .bbo_updated    (bbo_updated),
        .cfg_enable     (cfg_enable),
        .cfg_max_spread (cfg_max_spread),
        .cfg_order_qty  (cfg_order_qty),
        .m_axis         (m_axis),
        .orders_sent    (orders_sent),
        .rate_drops     (rate_drops)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] held;
    bit          have_held = 1'b0;

    // Output monitor: {tlast, tdata} compared against the queue on each handshake.
    always @(negedge clk) begin
        logic [32:0] got;
        logic [32:0] exp_w;
        if (!rst && m_axis.tvalid) begin
            got = {m_axis.tlast, m_axis.tdata};
            if (have_held) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL hold_stable: got %h required %h", got, held);
                end
            end
            if (m_axis.tready) begin
                have_held = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h required none", got);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got !== exp_w) begin
                        errors++;
                        $display("FAIL packet_word: got %h required %h", got, exp_w);
                    end
                end
            end else begin
                held      = got;
                have_held = 1'b1;
            end
        end else begin
            have_held = 1'b0;
        end
    end

    task automatic push_pkt(input logic [15:0] seq, input logic [31:0] bid,
                            input logic [31:0] ask, input logic [31:0] qty);
        exp_q.push_back({1'b0, MAGIC, seq});
        exp_q.push_back({1'b0, bid});
        exp_q.push_back({1'b0, ask});
        exp_q.push_back({1'b1, qty});
    endtask

    task automatic bbo(input logic [31:0] bid, input logic [31:0] ask);
        @(posedge clk); #1;
        best_bid    = bid;
        best_ask    = ask;
        bbo_updated = 1'b1;
        @(posedge clk); #1;
        bbo_updated = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_axis.tvalid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_drain: got %0d words left required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks += 5;
        if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_axis.tvalid); end
        if (m_axis.tlast !== 1'b0)  begin errors++; $display("FAIL rst_tlast: got %b required 0", m_axis.tlast); end
        if (m_axis.tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h required 0", m_axis.tdata); end
        if (orders_sent !== 16'd0)  begin errors++; $display("FAIL rst_orders: got %0d required 0", orders_sent); end
        if (rate_drops !== 16'd0)   begin errors++; $display("FAIL rst_drops: got %0d required 0", rate_drops); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        push_pkt(16'd0, 32'd100, 32'd105, 32'd50);
        bbo(32'd100, 32'd105);
        @(negedge clk);
        checks++;
        if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL latency_eval: got tvalid %b required 0", m_axis.tvalid); end
        @(negedge clk);
        checks++;
        if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 32'hA55A0000) begin
            errors++;
            $display("FAIL latency_w0: got %b/%h required 1/a55a0000", m_axis.tvalid, m_axis.tdata);
        end
        wait_drain("basic");
        checks++;
        if (orders_sent !== 16'd1) begin errors++; $display("FAIL basic_orders: got %0d required 1", orders_sent); end
    endtask

    task automatic test_reject();
        do_reset();
        bbo(32'd100, 32'd120);
        bbo(32'd0, 32'd105);
        bbo(32'd100, 32'd100);
        bbo(32'd100, 32'hFFFF_FFFF);
        cfg_enable = 1'b0;
        bbo(32'd100, 32'd105);
        wait_drain("reject");
        cfg_enable = 1'b1;
        checks += 2;
        if (orders_sent !== 16'd0) begin errors++; $display("FAIL reject_orders: got %0d required 0", orders_sent); end
        if (rate_drops !== 16'd0)  begin errors++; $display("FAIL reject_drops: got %0d required 0", rate_drops); end
        // Spread exactly at the limit is accepted.
        push_pkt(16'd0, 32'd100, 32'd110, 32'd50);
        bbo(32'd100, 32'd110);
        wait_drain("spread_edge");
    endtask

    task automatic test_dedup();
        do_reset();
        cfg_order_qty = 32'd77;
        push_pkt(16'd0, 32'd100, 32'd105, 32'd77);
        bbo(32'd100, 32'd105);
        wait_drain("dedup_first");
        bbo(32'd100, 32'd105);
        wait_drain("dedup_repeat");
        push_pkt(16'd1, 32'd100, 32'd104, 32'd77);
        bbo(32'd100, 32'd104);
        wait_drain("dedup_new");
        cfg_order_qty = 32'd50;
        checks++;
        if (orders_sent !== 16'd2) begin errors++; $display("FAIL dedup_orders: got %0d required 2", orders_sent); end
    endtask

    task automatic test_rate_limit();
        do_reset();
        push_pkt(16'd0, 32'd100, 32'd105, 32'd50);
        bbo(32'd100, 32'd105);
        repeat (8) @(posedge clk);
        push_pkt(16'd1, 32'd100, 32'd104, 32'd50);
        bbo(32'd100, 32'd104);
        repeat (8) @(posedge clk);
        bbo(32'd100, 32'd103);
        wait_drain("rate");
        checks += 2;
        if (rate_drops !== 16'd1)  begin errors++; $display("FAIL rate_drops: got %0d required 1", rate_drops); end
        if (orders_sent !== 16'd2) begin errors++; $display("FAIL rate_orders: got %0d required 2", orders_sent); end
        repeat (REFILL_CYCLES) @(posedge clk);
        push_pkt(16'd2, 32'd100, 32'd102, 32'd50);
        bbo(32'd100, 32'd102);
        wait_drain("refill");
        checks++;
        if (orders_sent !== 16'd3) begin errors++; $display("FAIL refill_orders: got %0d required 3", orders_sent); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        push_pkt(16'd0, 32'd100, 32'd105, 32'd50);
        push_pkt(16'd1, 32'd102, 32'd104, 32'd50);
        bbo(32'd100, 32'd105);
        while (!m_axis.tvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        tready = 1'b0;
        bbo(32'd101, 32'd104);
        @(negedge clk);
        checks++;
        if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 32'd100) begin
            errors++;
            $display("FAIL stall_word1: got %b/%h required 1/%h", m_axis.tvalid, m_axis.tdata, 32'd100);
        end
        bbo(32'd102, 32'd104);
        @(posedge clk); #1;
        tready = 1'b1;
        wait_drain("b2b");
        checks++;
        if (orders_sent !== 16'd2) begin errors++; $display("FAIL b2b_orders: got %0d required 2", orders_sent); end
    endtask

    task automatic test_reset_mid_packet();
        int n = 0;
        do_reset();
        push_pkt(16'd0, 32'd100, 32'd105, 32'd50);
        bbo(32'd100, 32'd105);
        while (!(m_axis.tvalid && m_axis.tdata == 32'd105) && n < 20) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL async_rst_tvalid: got %b required 0", m_axis.tvalid); end
        if (orders_sent !== 16'd0)  begin errors++; $display("FAIL async_rst_orders: got %0d required 0", orders_sent); end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_pkt(16'd0, 32'd100, 32'd105, 32'd50);
        bbo(32'd100, 32'd105);
        wait_drain("post_rst_a");
        push_pkt(16'd1, 32'd100, 32'd104, 32'd50);
        bbo(32'd100, 32'd104);
        wait_drain("post_rst_b");
        checks += 2;
        if (orders_sent !== 16'd2) begin errors++; $display("FAIL post_rst_orders: got %0d required 2", orders_sent); end
        if (rate_drops !== 16'd0)  begin errors++; $display("FAIL post_rst_drops: got %0d required 0", rate_drops); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_dedup();
        test_rate_limit();
        test_back_to_back();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quote_order_gen.md
Name: quote_order_gen

Overview:
Sits directly downstream of book_builder and consumes its best_bid / best_ask / bbo_updated outputs. Evaluates each BBO update against a configured maximum spread and emits a two-sided quote order as a 4-word 32-bit AXI-Stream packet toward the order-egress path. Includes a token-bucket rate limiter, de-duplication of repeated quotes, a 1-deep pending-update buffer and statistics counters.

Parameters:
TOKEN_MAX, 4, bucket depth and reset token count (1..15)
REFILL_CYCLES, 1000, clk cycles per refilled token (>=1)
MAGIC, 16'hA55A, header tag placed in word0[31:16]

Ports:
clk  in  1  pipeline clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
best_bid  in  32  current best bid price from book_builder
best_ask  in  32  current best ask price from book_builder
bbo_updated  in  1  1-cycle strobe; best_bid/best_ask valid this cycle
cfg_enable  in  1  global quoting enable
cfg_max_spread  in  32  maximum allowed (ask - bid), unsigned
cfg_order_qty  in  32  quantity placed in word3
m_axis_tdata  out  32  order packet word
m_axis_tvalid  out  1  word valid
m_axis_tlast  out  1  high on word3
m_axis_tready  in  1  downstream ready
orders_sent  out  16  completed packets, wraps
rate_drops  out  16  triggers rejected for lack of tokens, wraps

Behaviour:
- Reset: all outputs 0, state IDLE, seq=0, tokens=TOKEN_MAX, refill counter=0, last-sent pair=0/0, pending=0. tvalid drops asynchronously, even mid-packet.
- Snapshot: on bbo_updated, latch bid/ask into snap regs. IDLE -> EVAL on the next cycle. In SEND, the snapshot overwrites the pending slot instead (1-deep; newest wins) and sets pending.
- EVAL (1 cycle): book valid = bid!=0 && ask!=32'hFFFFFFFF && ask>bid. Spread = ask-bid, 32-bit unsigned; no underflow possible given ask>bid. Trigger = cfg_enable && valid && spread<=cfg_max_spread && (bid,ask)!=last-sent pair. cfg_* is sampled in EVAL only.
- EVAL outcome with trigger and tokens>0: consume one token, record last-sent pair, go to SEND_W0.
- EVAL outcome with trigger and tokens==0: increment rate_drops, go to IDLE.
- EVAL outcome with no trigger: go to IDLE.
- Latency: bbo_updated at cycle N leads to tvalid with word0 at cycle N+2 when IDLE.
- SEND_W0..W3 word contents:
  - word0 = {MAGIC, seq}
  - word1 = bid
  - word2 = ask
  - word3 = cfg_order_qty latched in EVAL; tlast=1 on word3.
- AXIS rules: tvalid, tdata and tlast are held stable until tready. A state advances only on tvalid&&tready. tvalid is never retracted without a handshake, except on reset.
- On the word3 handshake: seq+1 (16-bit, 16'hFFFF wraps to 0) and orders_sent+1. Go to EVAL if pending (move pending to snap, clear pending), otherwise IDLE. No idle bubble is required between EVAL and W0.
- bbo_updated coincident with the word3 handshake: the new sample goes to snap directly and the state goes to EVAL; the older pending sample is discarded.
- Token bucket: the counter counts 0..REFILL_CYCLES-1. At wrap, tokens+1, saturating at TOKEN_MAX.
- Token consume and refill in the same cycle: tokens are unchanged.
- Refill runs continuously, independent of state.

Decomposition:
- Package quote_order_pkg holds:
  - state encoding: IDLE, EVAL, SEND_W0, SEND_W1, SEND_W2, SEND_W3
  - word index constants
  - BID_EMPTY=32'h0, ASK_EMPTY=32'hFFFFFFFF
  - default MAGIC
- Sub-module token_bucket (params TOKEN_MAX, REFILL_CYCLES).
  - Ports: clk, rst, consume in, has_token out.
  - Owns the refill counter and the saturation logic.

Test Plan:
1. cfg_enable=1, max_spread=10, qty=50, tready=1; bbo bid=100 ask=105 at cycle N -> words 0xA55A0000, 100, 105, 50 on cycles N+2..N+5; tlast on the 4th word; orders_sent=1.
2. bid=100 ask=120, max_spread=10 -> no tvalid. Also bid=0 ask=105, and ask=bid=100 -> no tvalid; counters unchanged.
3. bid=100 ask=105 sent, then same pair again -> no second packet. Then ask=104 -> packet with word0=0xA55A0001.
4. TOKEN_MAX=2, REFILL_CYCLES=10000; three distinct valid updates spaced 10 cycles -> 2 packets, rate_drops=1. After 10000 idle cycles a new update -> packet sent.
5. tready=0 for 5 cycles at word1; two bbo updates (101/104, then 102/104) arrive meanwhile -> word1 held stable. After tlast, one more packet with bid=102 ask=104; the 101/104 sample is never sent.
6. Assert rst during word2 -> tvalid=0 immediately. After release: tokens=TOKEN_MAX, seq restarts, and the next packet word0=0xA55A0000.
